// File: rtl/bb_pkg.sv
// Shared building-block helpers used across the datapath.
package bb_pkg;

  // Address width for n entries; never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_fwd_sel.sv
// Priority select over write ports: reports whether any enabled write port
// targets addr and returns the data of the highest-index matching port.
module rf_fwd_sel #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NWR   = 2
) (
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic [AW-1:0]        addr,
  output logic                 hit_c,
  output logic [WIDTH-1:0]     data_c
);

  // Later ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    hit_c  = 1'b0;
    data_c = '0;
    for (int unsigned i = 0; i < NWR; i++) begin
      if (we[i] && (wa[i*AW +: AW] == addr)) begin
        hit_c  = 1'b1;
        data_c = wd[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR bank with write-to-read bypass, async clear and a
// per-register busy scoreboard for multicycle producers.
module regfile_mp
  import bb_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = int'(clog2_min1(int'(NREGS)))
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    wa,
  input  logic [NWR*WIDTH-1:0] wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 bsy_set,
  input  logic [AW-1:0]        bsy_addr,
  output logic [NREGS-1:0]     busy
);

  logic [WIDTH-1:0] mem [NREGS];
  logic [NWR-1:0]   we_ok;
  logic [NREGS-1:0] clr_hit;
  logic [NREGS-1:0] clr_one;
  logic             bsy_ok;

  // Addressable: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Drop writes to r0 / out-of-range addresses before they reach anything.
  always_comb begin
    we_ok = '0;
    for (int unsigned i = 0; i < NWR; i++) begin
      we_ok[i] = we[i] && addr_ok(wa[i*AW +: AW]);
    end
  end

  assign bsy_ok = bsy_set && addr_ok(bsy_addr);

  // Storage; the highest-index port is applied last so it wins collisions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        for (int unsigned i = 0; i < NWR; i++) begin
          if (we_ok[i] && (wa[i*AW +: AW] == AW'(r))) begin
            mem[r] <= wd[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Per-register retire detection; the data lane carries a constant 1.
  for (genvar r = 0; r < int'(NREGS); r++) begin : g_clr
    rf_fwd_sel #(
      .WIDTH(1),
      .AW   (AW),
      .NWR  (NWR)
    ) u_clr (
      .we    (we_ok),
      .wa    (wa),
      .wd    ({NWR{1'b1}}),
      .addr  (AW'(r)),
      .hit_c (clr_hit[r]),
      .data_c(clr_one[r])
    );
  end

  // Scoreboard: a new producer issuing wins over an old one retiring.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (bsy_ok && (bsy_addr == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (clr_hit[r] && clr_one[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: forward same-cycle writes, otherwise the stored entry.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0]    ra_k;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [WIDTH-1:0] rd_k;
    logic             rd_busy_k;

    assign ra_k = ra[k*AW +: AW];

    rf_fwd_sel #(
      .WIDTH(WIDTH),
      .AW   (AW),
      .NWR  (NWR)
    ) u_fwd (
      .we    (we_ok),
      .wa    (wa),
      .wd    (wd),
      .addr  (ra_k),
      .hit_c (fwd_hit),
      .data_c(fwd_data)
    );

    // Mux the stored value and busy bit, then apply forwarding and reset.
    always_comb begin
      logic [WIDTH-1:0] stored;
      logic             bsy;
      stored    = '0;
      bsy       = 1'b0;
      rd_k      = '0;
      rd_busy_k = 1'b0;
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (ra_k == AW'(r)) begin
          stored = mem[r];
          bsy    = busy[r];
        end
      end
      if (reset || !addr_ok(ra_k)) begin
        rd_k      = '0;
        rd_busy_k = 1'b0;
      end else if ((BYPASS != 0) && fwd_hit) begin
        rd_k      = fwd_data;
        rd_busy_k = 1'b0;
      end else begin
        rd_k      = stored;
        rd_busy_k = bsy;
      end
    end

    assign rd[k*WIDTH +: WIDTH] = rd_k;
    assign rd_busy[k]           = rd_busy_k;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed checks for regfile_mp: default instance plus a 24-entry,
// no-bypass instance.
module tb_regfile_mp;

  logic        clk;
  logic        reset;

  logic [1:0]  a_we;
  logic [9:0]  a_wa;
  logic [63:0] a_wd;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rd_busy;
  logic        a_bsy_set;
  logic [4:0]  a_bsy_addr;
  logic [31:0] a_busy;

  logic [1:0]  b_we;
  logic [9:0]  b_wa;
  logic [63:0] b_wd;
  logic [9:0]  b_ra;
  logic [63:0] b_rd;
  logic [1:0]  b_rd_busy;
  logic        b_bsy_set;
  logic [4:0]  b_bsy_addr;
  logic [23:0] b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp u_a (
    .clk     (clk),
    .reset   (reset),
    .we      (a_we),
    .wa      (a_wa),
    .wd      (a_wd),
    .ra      (a_ra),
    .rd      (a_rd),
    .rd_busy (a_rd_busy),
    .bsy_set (a_bsy_set),
    .bsy_addr(a_bsy_addr),
    .busy    (a_busy)
  );

  regfile_mp #(
    .NREGS (24),
    .BYPASS(0)
  ) u_b (
    .clk     (clk),
    .reset   (reset),
    .we      (b_we),
    .wa      (b_wa),
    .wd      (b_wd),
    .ra      (b_ra),
    .rd      (b_rd),
    .rd_busy (b_rd_busy),
    .bsy_set (b_bsy_set),
    .bsy_addr(b_bsy_addr),
    .busy    (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we = '0; a_wa = '0; a_wd = '0; a_bsy_set = 1'b0; a_bsy_addr = '0;
    b_we = '0; b_wa = '0; b_wd = '0; b_bsy_set = 1'b0; b_bsy_addr = '0;
  endtask

  initial begin
    idle();
    a_ra  = '0;
    b_ra  = '0;
    reset = 1'b1;
    #12;
    chk("reset_busy", a_busy, 32'h0);
    reset = 1'b0;
    #1;

    // 1: every register reads zero after reset
    for (int r = 0; r < 32; r++) begin
      a_ra = {5'(31 - r), 5'(r)};
      #1;
      chk("rst_rd0", a_rd[31:0], 32'h0);
      chk("rst_rd1", a_rd[63:32], 32'h0);
    end
    chk("rst_rd_busy", {30'h0, a_rd_busy}, 32'h0);
    chk("rst_busy_b", {8'h0, b_busy}, 32'h0);

    // 2: bypass on instance A, stored-only on instance B
    tick();
    a_we = 2'b01; a_wa = {5'd0, 5'd5}; a_wd = {32'h0, 32'hDEADBEEF}; a_ra = {5'd0, 5'd5};
    b_we = 2'b01; b_wa = {5'd0, 5'd5}; b_wd = {32'h0, 32'hDEADBEEF}; b_ra = {5'd0, 5'd5};
    #1;
    chk("byp_same", a_rd[31:0], 32'hDEADBEEF);
    chk("nobyp_same", b_rd[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("byp_next", a_rd[31:0], 32'hDEADBEEF);
    chk("nobyp_next", b_rd[31:0], 32'hDEADBEEF);

    // 3: port collision (port 1 wins) and r0 hardwired
    a_we = 2'b11; a_wa = {5'd7, 5'd7}; a_wd = {32'd2, 32'd1}; a_ra = {5'd0, 5'd7};
    #1;
    chk("coll_byp", a_rd[31:0], 32'd2);
    tick();
    idle();
    #1;
    chk("coll_stored", a_rd[31:0], 32'd2);
    a_we = 2'b01; a_wa = {5'd0, 5'd0}; a_wd = {32'h0, 32'hFF}; a_ra = {5'd0, 5'd0};
    #1;
    chk("r0_byp", a_rd[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("r0_stored", a_rd[31:0], 32'h0);

    // 4: scoreboard set / clear / set-wins
    a_bsy_set = 1'b1; a_bsy_addr = 5'd9; a_ra = {5'd9, 5'd0};
    #1;
    chk("bsy_pre", {30'h0, a_rd_busy}, 32'h0);
    tick();
    idle();
    #1;
    chk("bsy_set", a_busy, 32'h200);
    chk("bsy_rd", {30'h0, a_rd_busy}, 32'h2);
    a_we = 2'b01; a_wa = {5'd0, 5'd9}; a_wd = {32'h0, 32'h99};
    #1;
    chk("bsy_fwd_rd", {30'h0, a_rd_busy}, 32'h0);
    chk("bsy_hold", a_busy, 32'h200);
    tick();
    idle();
    #1;
    chk("bsy_clr", a_busy, 32'h0);
    chk("bsy_clr_data", a_rd[63:32], 32'h99);
    a_bsy_set = 1'b1; a_bsy_addr = 5'd9;
    a_we = 2'b10; a_wa = {5'd9, 5'd0}; a_wd = {32'hAA, 32'h0};
    tick();
    idle();
    #1;
    chk("bsy_setwins", a_busy, 32'h200);
    a_bsy_set = 1'b1; a_bsy_addr = 5'd0;
    tick();
    idle();
    #1;
    chk("bsy_r0", a_busy, 32'h200);

    // 5: out-of-range accesses on the 24-entry instance
    b_we = 2'b01; b_wa = {5'd23, 5'd30}; b_wd = {32'h0, 32'h1234}; b_ra = {5'd24, 5'd30};
    #1;
    chk("oor_rd_same", b_rd[31:0], 32'h0);
    tick();
    idle();
    b_we = 2'b10; b_wa = {5'd23, 5'd0}; b_wd = {32'h5A5A, 32'h0};
    b_bsy_set = 1'b1; b_bsy_addr = 5'd30;
    tick();
    idle();
    b_ra = {5'd23, 5'd30};
    #1;
    chk("oor_rd", b_rd[31:0], 32'h0);
    chk("oor_busy", {8'h0, b_busy}, 32'h0);
    chk("top_reg", b_rd[63:32], 32'h5A5A);
    b_ra = {5'd0, 5'd24};
    #1;
    chk("oor_rd24", b_rd[31:0], 32'h0);

    // 6: ten writes, then reset between edges with a write pending
    for (int r = 10; r < 20; r += 2) begin
      a_we = 2'b11;
      a_wa = {5'(r + 1), 5'(r)};
      a_wd = {32'(32'h100 + r + 1), 32'(32'h100 + r)};
      tick();
    end
    idle();
    a_bsy_set = 1'b1; a_bsy_addr = 5'd21;
    tick();
    idle();
    a_ra = {5'd20, 5'd12};
    #1;
    chk("pre_rst_rd", a_rd[31:0], 32'h10C);
    chk("pre_rst_busy", a_busy, 32'h0020_0200);
    a_we = 2'b01; a_wa = {5'd0, 5'd20}; a_wd = {32'h0, 32'h55};
    #1;
    chk("pre_rst_byp", a_rd[63:32], 32'h55);
    reset = 1'b1;
    #1;
    chk("mid_rst_rd0", a_rd[31:0], 32'h0);
    chk("mid_rst_rd1", a_rd[63:32], 32'h0);
    chk("mid_rst_busy", a_busy, 32'h0);
    chk("mid_rst_rd_busy", {30'h0, a_rd_busy}, 32'h0);
    tick();
    idle();
    reset = 1'b0;
    #1;
    chk("post_rst_r20", a_rd[63:32], 32'h0);
    chk("post_rst_r12", a_rd[31:0], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
